// File: rtl/dcm_prog_responder.sv
// Responder for the DCM_CLKGEN PROGEN/PROGDATA/PROGDONE port: decodes LoadD/LoadM/GO,
// holds pending/active D and M, and times the relock. Optional macro: DCM_RANGE_CHECK_EN.
module dcm_prog_responder #(
  parameter int INITIAL_MULTIPLIER = 60,
  parameter int INITIAL_DIVIDER    = 8,
  parameter int MAXIMUM_MULTIPLIER = 88,
  parameter int DONE_DELAY         = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       prog_en,
  input  logic       prog_data,
  output logic       prog_done,
  output logic [8:0] multiplier,
  output logic [8:0] divider,
  output logic       cfg_valid,
  output logic       proto_error,
  input  logic       error_clear
);

  localparam int              CW      = $clog2(DONE_DELAY + 1);
  localparam logic [CW-1:0]   DLY     = CW'(DONE_DELAY);
  localparam logic [CW-1:0]   ONE     = CW'(1);
  localparam logic [7:0]      INIT_M1 = 8'(INITIAL_MULTIPLIER - 1);
  localparam logic [7:0]      INIT_D1 = 8'(INITIAL_DIVIDER - 1);
  localparam logic [8:0]      M_MAX   = 9'(MAXIMUM_MULTIPLIER);
`ifdef DCM_RANGE_CHECK_EN
  localparam bit              RANGE_CHK = 1'b1;
`else
  localparam bit              RANGE_CHK = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, CMD, SHIFT, TAIL, RELOCK} state_t;

  // One-cycle event produced by the command decoder
  typedef struct packed {
    logic       wr;
    logic       tgt_m;
    logic [7:0] val;
    logic       go;
    logic       err;
  } dec_evt_t;

  // Decoder walks IDLE/CMD/SHIFT/TAIL; the relock timer walks IDLE/RELOCK so loads
  // keep decoding while the timer runs.
  state_t        dec_state, dec_next;
  state_t        lock_state, lock_next;
  logic [7:0]    shreg, shreg_next;
  logic [2:0]    bit_cnt, bit_cnt_next;
  logic          tgt_m, tgt_m_next;
  logic          tail_err, tail_err_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          done_q, done_next;
  logic          commit, go_err, range_ok;
  logic [7:0]    pend_m, pend_d, act_m, act_d;
  logic [8:0]    pend_m_p1, pend_d_p1;
  dec_evt_t      evt;

  assign pend_m_p1 = {1'b0, pend_m} + 9'd1;
  assign pend_d_p1 = {1'b0, pend_d} + 9'd1;
  // With the check disabled this folds to a constant 1 and no compare logic remains.
  assign range_ok  = !RANGE_CHK ||
                     ((pend_m_p1 >= 9'd2) && (pend_m_p1 <= M_MAX) && (pend_d_p1 >= 9'd1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_state  <= IDLE;
      lock_state <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      tgt_m      <= 1'b0;
      tail_err   <= 1'b0;
      cnt        <= '0;
      done_q     <= 1'b1;
    end else begin
      dec_state  <= dec_next;
      lock_state <= lock_next;
      shreg      <= shreg_next;
      bit_cnt    <= bit_cnt_next;
      tgt_m      <= tgt_m_next;
      tail_err   <= tail_err_next;
      cnt        <= cnt_next;
      done_q     <= done_next;
    end
  end

  always_comb begin
    dec_next      = dec_state;
    shreg_next    = shreg;
    bit_cnt_next  = bit_cnt;
    tgt_m_next    = tgt_m;
    tail_err_next = tail_err;
    evt           = '0;
    case (dec_state)
      IDLE: begin
        if (prog_en) begin
          if (prog_data) dec_next = CMD;
          else           evt.go   = 1'b1;
        end
      end
      CMD: begin
        if (prog_en) begin
          tgt_m_next   = prog_data;
          bit_cnt_next = '0;
          shreg_next   = '0;
          dec_next     = SHIFT;
        end else begin
          evt.err  = 1'b1;
          dec_next = IDLE;
        end
      end
      SHIFT: begin
        if (prog_en) begin
          // LSB-first on the wire: enter at the MSB so bit 0 holds the first bit
          shreg_next   = {prog_data, shreg[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            evt.wr        = 1'b1;
            evt.tgt_m     = tgt_m;
            evt.val       = shreg_next;
            tail_err_next = 1'b0;
            dec_next      = TAIL;
          end
        end else begin
          evt.err  = 1'b1;
          dec_next = IDLE;
        end
      end
      TAIL: begin
        if (prog_en) begin
          evt.err       = !tail_err;
          tail_err_next = 1'b1;
        end else begin
          dec_next = IDLE;
        end
      end
      default: dec_next = IDLE;
    endcase
  end

  always_comb begin
    lock_next = lock_state;
    cnt_next  = cnt;
    done_next = done_q;
    commit    = 1'b0;
    go_err    = 1'b0;
    case (lock_state)
      IDLE: begin
        if (evt.go) begin
          // A rejected GO still runs the full relock so the initiator sees prog_done
          lock_next = RELOCK;
          cnt_next  = DLY;
          done_next = 1'b0;
          commit    = range_ok;
          go_err    = !range_ok;
        end
      end
      RELOCK: begin
        go_err = evt.go;
        if (cnt == ONE) begin
          cnt_next  = '0;
          done_next = 1'b1;
          lock_next = IDLE;
        end else begin
          cnt_next = cnt - ONE;
        end
      end
      default: lock_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_m      <= INIT_M1;
      pend_d      <= INIT_D1;
      act_m       <= INIT_M1;
      act_d       <= INIT_D1;
      cfg_valid   <= 1'b0;
      proto_error <= 1'b0;
    end else begin
      if (evt.wr) begin
        if (evt.tgt_m) pend_m <= evt.val;
        else           pend_d <= evt.val;
      end
      if (commit) begin
        act_m <= pend_m;
        act_d <= pend_d;
      end
      cfg_valid <= commit;
      if (evt.err || go_err) proto_error <= 1'b1;
      else if (error_clear)  proto_error <= 1'b0;
    end
  end

  assign prog_done  = done_q;
  assign multiplier = {1'b0, act_m} + 9'd1;
  assign divider    = {1'b0, act_d} + 9'd1;

endmodule

// File: tb/tb_dcm_prog_responder.sv
// Directed bench for dcm_prog_responder: load/GO sequencing, relock timing, error paths.
module tb_dcm_prog_responder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       prog_en;
  logic       prog_data;
  logic       prog_done;
  logic [8:0] multiplier;
  logic [8:0] divider;
  logic       cfg_valid;
  logic       proto_error;
  logic       error_clear;

  int checks = 0;
  int errors = 0;
  int low, pulses, pre;

  dcm_prog_responder dut (
    .clk(clk), .reset_n(reset_n), .prog_en(prog_en), .prog_data(prog_data),
    .prog_done(prog_done), .multiplier(multiplier), .divider(divider),
    .cfg_valid(cfg_valid), .proto_error(proto_error), .error_clear(error_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Drive one wire bit, advance past the next rising edge
  task automatic tick(input logic en, input logic d);
    prog_en   = en;
    prog_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic m, input logic [7:0] v);
    tick(1'b1, 1'b1);
    tick(1'b1, m);
    for (int i = 0; i < 8; i++) tick(1'b1, v[i]);
  endtask

  task automatic go();
    tick(1'b1, 1'b0);
  endtask

  task automatic clr();
    error_clear = 1'b1;
    tick(1'b0, 1'b0);
    error_clear = 1'b0;
  endtask

  // Count remaining low cycles and cfg_valid pulses until prog_done rises (bounded)
  task automatic wait_hi(output int lo, output int pu);
    lo = 0;
    pu = 0;
    for (int i = 0; i < 40; i++) begin
      if (prog_done) break;
      lo++;
      tick(1'b0, 1'b0);
      if (cfg_valid) pu++;
    end
  endtask

  initial begin
    reset_n = 1'b0; prog_en = 1'b0; prog_data = 1'b0; error_clear = 1'b0;
    #22 reset_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_mult", multiplier, 60);
    chk("rst_div", divider, 8);
    chk("rst_done", prog_done, 1);
    chk("rst_err", proto_error, 0);
    chk("rst_cfgv", cfg_valid, 0);

    // Basic load/commit
    load(1'b0, 8'h07); repeat (3) tick(1'b0, 1'b0);
    load(1'b1, 8'h3C); repeat (2) tick(1'b0, 1'b0);
    go();
    chk("go1_cfgv", cfg_valid, 1);
    chk("go1_done_low", prog_done, 0);
    chk("go1_mult", multiplier, 61);
    chk("go1_div", divider, 8);
    wait_hi(low, pulses);
    chk("go1_low_cycles", low, 16);
    chk("go1_extra_pulses", pulses, 0);
    chk("go1_err", proto_error, 0);

    // Aborted LoadM keeps pending M
    load(1'b1, 8'h3B); tick(1'b0, 1'b0);
    tick(1'b1, 1'b1); tick(1'b1, 1'b1);
    repeat (5) tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    chk("abort_err", proto_error, 1);
    go();
    chk("abort_cfgv", cfg_valid, 1);
    chk("abort_mult", multiplier, 60);
    wait_hi(low, pulses);

    // GO during relock is rejected and does not stretch the relock
    clr();
    chk("clr_err", proto_error, 0);
    load(1'b0, 8'h03); tick(1'b0, 1'b0);
    go();
    chk("rgo_div", divider, 4);
    pre = 0;
    repeat (3) begin
      if (!prog_done) pre++;
      tick(1'b0, 1'b0);
    end
    if (!prog_done) pre++;
    go();
    chk("rgo_err", proto_error, 1);
    chk("rgo_no_cfgv", cfg_valid, 0);
    wait_hi(low, pulses);
    chk("rgo_low_cycles", pre + low, 16);
    chk("rgo_pulses", pulses, 0);

    // Load during relock only touches pending
    clr();
    go();
    chk("rl_cfgv", cfg_valid, 1);
    load(1'b1, 8'h3C); tick(1'b0, 1'b0);
    chk("rl_still_relock", prog_done, 0);
    chk("rl_mult_held", multiplier, 60);
    wait_hi(low, pulses);
    chk("rl_err", proto_error, 0);
    go();
    chk("rl_mult_new", multiplier, 61);
    wait_hi(low, pulses);

    // Out-of-range M
    load(1'b1, 8'h63); tick(1'b0, 1'b0);
    go();
`ifdef DCM_RANGE_CHECK_EN
    chk("rng_cfgv", cfg_valid, 0);
    chk("rng_mult", multiplier, 61);
    chk("rng_err", proto_error, 1);
`else
    chk("rng_cfgv", cfg_valid, 1);
    chk("rng_mult", multiplier, 100);
    chk("rng_err", proto_error, 0);
`endif
    chk("rng_done_low", prog_done, 0);
    wait_hi(low, pulses);
    chk("rng_low_cycles", low + 1, 17);
    clr();
    chk("rng_clr", proto_error, 0);

    // Extra bits in TAIL flag an error and are ignored
    load(1'b1, 8'h3B); tick(1'b0, 1'b0);
    load(1'b0, 8'h01);
    tick(1'b1, 1'b0); tick(1'b1, 1'b1); tick(1'b0, 1'b0);
    chk("tail_err", proto_error, 1);
    clr();
    go();
    chk("tail_div", divider, 2);
    chk("tail_mult", multiplier, 60);
    chk("tail_err_clear", proto_error, 0);
    wait_hi(low, pulses);

    // New error beats a same-cycle clear
    tick(1'b1, 1'b1);
    error_clear = 1'b1;
    tick(1'b0, 1'b0);
    error_clear = 1'b0;
    chk("prio_err", proto_error, 1);

    // Reset mid-relock and mid-command
    load(1'b1, 8'h3C); tick(1'b0, 1'b0);
    go();
    tick(1'b1, 1'b1); tick(1'b1, 1'b0); tick(1'b1, 1'b1);
    reset_n = 1'b0;
    #2;
    chk("mrst_mult", multiplier, 60);
    chk("mrst_div", divider, 8);
    chk("mrst_done", prog_done, 1);
    chk("mrst_err", proto_error, 0);
    #4 reset_n = 1'b1;
    tick(1'b0, 1'b0);
    go();
    chk("mrst_go_cfgv", cfg_valid, 1);
    chk("mrst_go_mult", multiplier, 60);
    chk("mrst_go_div", divider, 8);
    wait_hi(low, pulses);
    chk("mrst_low_cycles", low, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcm_prog_responder.md
Name: dcm_prog_responder

Overview:
- Responder end of the DCM_CLKGEN serial programming port (PROGEN/PROGDATA/PROGDONE), clocked by the programming clock.
- Decodes LoadD, LoadM and GO commands from the clock-retune initiator, holds pending and active D/M values, and drives prog_done with a programmable relock delay.
- Used two ways: as the bench model of the DCM, and as the front end of a soft clock-generator retune path.

Parameters:
- INITIAL_MULTIPLIER, 60, active M after reset (1..256).
- INITIAL_DIVIDER, 8, active D after reset (1..256).
- MAXIMUM_MULTIPLIER, 88, upper M bound used by the range check.
- DONE_DELAY, 16, cycles prog_done stays low after an accepted GO (>=1).

Ports:
- clk  in  1  programming clock; everything is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- prog_en  in  1  PROGEN from the initiator.
- prog_data  in  1  PROGDATA from the initiator.
- prog_done  out  1  PROGDONE: high = idle and locked; low = relock in progress.
- multiplier  out  9  active M value (register value + 1).
- divider  out  9  active D value (register value + 1).
- cfg_valid  out  1  one-cycle pulse when a GO commits new active values.
- proto_error  out  1  sticky protocol or range error flag.
- error_clear  in  1  synchronous clear of proto_error.

Behaviour:
- Reset values:
  - prog_done=1, cfg_valid=0, proto_error=0.
  - multiplier=INITIAL_MULTIPLIER, divider=INITIAL_DIVIDER.
  - pending M-1 = INITIAL_MULTIPLIER-1, pending D-1 = INITIAL_DIVIDER-1.
  - FSM in IDLE.
- Wire protocol (one bit per clk, sampled while prog_en=1):
  - LoadD = 1,0 then 8 data bits, LSB first.
  - LoadM = 1,1 then 8 data bits, LSB first.
  - GO = single 0.
  - prog_en=0 between commands.
- FSM states: IDLE, CMD, SHIFT, TAIL, RELOCK.
- IDLE:
  - prog_en=1, data=1 -> CMD.
  - prog_en=1, data=0 -> GO handling.
- GO handling:
  - Not in RELOCK -> copy pending to active, pulse cfg_valid next cycle, drive prog_done=0 next cycle, enter RELOCK.
- CMD:
  - prog_en=1 -> latch target (data=0 -> D, data=1 -> M), clear bit counter, go to SHIFT.
  - prog_en=0 -> set proto_error, go to IDLE.
- SHIFT:
  - prog_en=1 -> shift data into an 8-bit shifter from the MSB side, so the first bit lands in bit 0 after 8 shifts.
  - On the 8th bit, write the target pending register and go to TAIL.
  - prog_en=0 before 8 bits -> set proto_error, discard the partial shift, pending register unchanged, go to IDLE.
- TAIL:
  - prog_en=0 -> IDLE.
  - prog_en=1 -> set proto_error once, stay in TAIL until prog_en=0. Extra bits are ignored.
- RELOCK:
  - Down-counter loaded with DONE_DELAY. prog_done stays low while it runs.
  - On reaching 0, prog_done=1 on the following cycle and the FSM returns to IDLE.
  - LoadD/LoadM sequences are still decoded in parallel and update the pending registers only.
  - A GO seen during RELOCK sets proto_error and is ignored (no commit, counter not restarted).
- Decoding concurrent with RELOCK: a parallel decoder path handles this; only the relock timer is exclusive.
- Active values are updated only by GO, never directly by a Load.
- Back-to-back commands with zero idle cycles between TAIL and the next command's first bit are legal.
- error_clear has priority below a same-cycle new error: the error wins and proto_error stays 1.
- Reset asserted mid-command or mid-RELOCK: return immediately to the reset values. The partial command is lost.

Optional Feature:
- Macro DCM_RANGE_CHECK_EN.
- Defined: at GO, if pending M+1 < 2, pending M+1 > MAXIMUM_MULTIPLIER, or pending D+1 < 1:
  - no commit and no cfg_valid;
  - proto_error is set;
  - prog_done still performs the full low pulse of DONE_DELAY cycles, so the initiator does not hang.
- Undefined: every GO outside RELOCK commits with no bound checks.

Test Plan:
- Reset release -> multiplier=60, divider=8, prog_done=1, proto_error=0, cfg_valid=0.
- Send LoadD 0x07, then 3 idle cycles, LoadM 0x3C, 2 idle cycles, GO:
  - cfg_valid pulses once, multiplier=61, divider=8;
  - prog_done low for exactly 16 cycles, then high;
  - proto_error stays 0.
- LoadM with prog_en dropped after 5 data bits -> proto_error=1, pending M unchanged. A following GO commits the old M (60).
- GO issued 4 cycles into RELOCK -> proto_error=1, prog_done rises at the original time, no second cfg_valid.
- LoadM 0x3C during RELOCK -> active M unchanged until the next GO, which then yields multiplier=61.
- DCM_RANGE_CHECK_EN defined, LoadM 0x63 (M=100) then GO:
  - no cfg_valid, multiplier unchanged, proto_error=1;
  - prog_done still low for 16 cycles, then high.
  - Then assert error_clear for one cycle -> proto_error=0.
